fetch_queue_unit: RTL

//  Decoupled, parametrised instruction-fetch front end for the RV32 pipeline.

---
 rtl/fetch_queue_unit_if.sv | 28 ++
 rtl/fetch_queue_unit.sv | 81 ++++++++
 2 files changed

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: icache request/response, redirect and decode handshake bundle
interface fetch_queue_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                       icache_req_valid;
    logic                       icache_req_ready;
    logic [XLEN-1:0]            icache_addr;
    logic                       icache_resp_valid;
    logic [31:0]                icache_dout;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic                       inst_valid;
    logic                       inst_ready;
    logic [31:0]                inst_out;
    logic [XLEN-1:0]            pc_out;
    logic [$clog2(DEPTH+1)-1:0] queue_count;

    modport master (
        output icache_req_valid, icache_addr, inst_valid, inst_out, pc_out, queue_count,
        input  icache_req_ready, icache_resp_valid, icache_dout, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  icache_req_valid, icache_addr, inst_valid, inst_out, pc_out, queue_count,
        output icache_req_ready, icache_resp_valid, icache_dout, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: credit-limited instruction fetch with PC-tagged prefetch queue and redirect flush
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000
) (
    input logic clk,
    input logic reset,
    fetch_queue_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] target;
    logic [1:0]      unused_lsb;
    logic            resp_ok, req_fire, push, pop;

    assign target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_lsb = bus.redirect_pc[1:0];
    assign resp_ok    = bus.icache_resp_valid && outstanding != '0;
    assign req_fire   = bus.icache_req_valid && bus.icache_req_ready;
    assign push       = resp_ok && drop_cnt == '0 && !bus.redirect_valid;
    assign pop        = count != '0 && bus.inst_ready && !bus.redirect_valid;

    assign bus.icache_req_valid = reset && !bus.redirect_valid && ({1'b0, count} + {1'b0, outstanding} < FULL);
    assign bus.icache_addr      = fetch_pc;
    assign bus.inst_valid       = count != '0;
    assign bus.inst_out         = mem_inst[rd_ptr];
    assign bus.pc_out           = mem_pc[rd_ptr];
    assign bus.queue_count      = count;

    // fetch/response PCs, credit counters, queue pointers; a redirect overrides every other update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (bus.redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                count    <= '0;
                rd_ptr   <= wr_ptr;
                drop_cnt <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (resp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // queue storage: each accepted response is written with the PC it was fetched from
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (push) begin
            mem_inst[wr_ptr] <= bus.icache_dout;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule
